// File: rtl/lcd8080_pkg.sv
// Shared types for the 8080-style LCD stream writer: FSM state encoding,
// the per-entry control fields stored in the FIFO and counter-width helpers.
// Optional feature macro: LCD8080_REPEAT_EN (per-entry repeat count).
package lcd8080_pkg;

    // Width of the per-entry repeat count (matches the in_count port).
    localparam int REP_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WR_LO,
        WR_HI,
        CS_GAP
    } state_e;

    // Control fields that travel with each word through the FIFO.
    typedef struct packed {
`ifdef LCD8080_REPEAT_EN
        logic [REP_W-1:0] count;
`endif
        logic             rs;
        logic             last;
    } entry_ctrl_t;

    // Bits needed for a down-counter that starts at n-1.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd8080_stream_writer_if.sv
// Valid/ready word stream feeding the LCD writer. The source drives the
// master modport, the writer consumes through the slave modport.
// Optional feature macro: LCD8080_REPEAT_EN adds in_count.
interface lcd8080_stream_writer_if
    import lcd8080_pkg::*;
#(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_rs;
    logic              in_last;
`ifdef LCD8080_REPEAT_EN
    logic [REP_W-1:0]  in_count;
`endif

    modport master (
`ifdef LCD8080_REPEAT_EN
        output in_count,
`endif
        output in_valid, in_data, in_rs, in_last,
        input  in_ready
    );

    modport slave (
`ifdef LCD8080_REPEAT_EN
        input  in_count,
`endif
        input  in_valid, in_data, in_rs, in_last,
        output in_ready
    );

endinterface

// File: rtl/lcd8080_fifo.sv
// Synchronous first-word-fall-through FIFO with level output. Besides the
// head entry it exposes the entry behind it, so the writer can load the
// next word in the same cycle it retires the current one.
module lcd8080_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    output logic                       ready_o,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [WIDTH-1:0]           next_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             ready_q, ready_d;
    logic             do_push, do_pop;

    // ready_q is registered, so a full FIFO refuses a push even when a pop
    // happens in the same cycle.
    assign do_push = push_i & ready_q;
    assign do_pop  = pop_i & (level_q != '0);

    // Next-state pointers, level and ready flag.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        level_d  = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
        ready_d  = (level_d != LVL_W'(DEPTH));
    end

    // Pointer, level and ready registers; reset flushes the FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ready_q  <= ready_d;
        end
    end

    // Storage write port.
    // NOTE: the array has no reset; the pointers and level define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[rd_ptr_q + PTR_W'(1)];
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign ready_o = ready_q;

endmodule

// File: rtl/lcd8080_stream_writer.sv
// 8080-style parallel LCD write engine: buffers command/data words from a
// valid/ready stream and drives CS/RS/RD/WR/DATA with programmable strobe
// timing. The word being written stays at the FIFO head until its strobe
// (and any repeats) complete.
// Optional feature macro: LCD8080_REPEAT_EN (write each word in_count+1 times).
module lcd8080_stream_writer
    import lcd8080_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int WR_LOW_CYC  = 2,
    parameter int WR_HIGH_CYC = 2,
    parameter int CS_IDLE_CYC = 1
) (
    input  logic                            clk_clk,
    input  logic                            reset_reset_n,
    lcd8080_stream_writer_if.slave          s_if,
    output logic                            lcd_cs_n,
    output logic                            lcd_rs,
    output logic                            lcd_rd_n,
    output logic                            lcd_wr_n,
    output logic [DATA_W-1:0]               lcd_data,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W = cnt_w(max3(WR_LOW_CYC, WR_HIGH_CYC, CS_IDLE_CYC));

    typedef struct packed {
        logic [DATA_W-1:0] data;
        entry_ctrl_t       ctrl;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    entry_t            push_entry, head, nxt;
    logic              fifo_empty, pop;
    logic              unused_nxt_last;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rs_q, rs_d;
    logic              cs_n_q, wr_n_q;
`ifdef LCD8080_REPEAT_EN
    logic [REP_W-1:0]  rep_q, rep_d;
`endif

    // Pack the offered word into a FIFO entry.
    always_comb begin
        push_entry           = '0;
        push_entry.data      = s_if.in_data;
        push_entry.ctrl.rs   = s_if.in_rs;
        push_entry.ctrl.last = s_if.in_last;
`ifdef LCD8080_REPEAT_EN
        push_entry.ctrl.count = s_if.in_count;
`endif
    end

    lcd8080_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_clk),
        .rst_ni      (reset_reset_n),
        .push_i      (s_if.in_valid),
        .push_data_i (push_entry),
        .ready_o     (s_if.in_ready),
        .pop_i       (pop),
        .head_o      (head),
        .next_o      (nxt),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level)
    );

    // The last flag of the following entry is only acted on once it is the head.
    assign unused_nxt_last = nxt.ctrl.last;

    // Strobe sequencer: next state, phase counter, repeat counter and bus load.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rs_d    = rs_q;
        pop     = 1'b0;
`ifdef LCD8080_REPEAT_EN
        rep_d   = rep_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    data_d  = head.data;
                    rs_d    = head.ctrl.rs;
`ifdef LCD8080_REPEAT_EN
                    rep_d   = head.ctrl.count;
`endif
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = WR_LO;
                cnt_d   = CNT_W'(WR_LOW_CYC - 1);
            end
            WR_LO: begin
                if (cnt_q == '0) begin
                    state_d = WR_HI;
                    cnt_d   = CNT_W'(WR_HIGH_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WR_HI: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
`ifdef LCD8080_REPEAT_EN
                end else if (rep_q != '0) begin
                    rep_d   = rep_q - 1'b1;
                    state_d = WR_LO;
                    cnt_d   = CNT_W'(WR_LOW_CYC - 1);
`endif
                end else if (head.ctrl.last) begin
                    pop     = 1'b1;
                    state_d = CS_GAP;
                    cnt_d   = CNT_W'(CS_IDLE_CYC - 1);
                end else if (fifo_level >= LVL_W'(2)) begin
                    // Retire the current head and strobe the entry behind it.
                    pop     = 1'b1;
                    data_d  = nxt.data;
                    rs_d    = nxt.ctrl.rs;
`ifdef LCD8080_REPEAT_EN
                    rep_d   = nxt.ctrl.count;
`endif
                    state_d = WR_LO;
                    cnt_d   = CNT_W'(WR_LOW_CYC - 1);
                end
                // Otherwise hold in WR_HI with cs_n low until a word arrives.
            end
            CS_GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered panel outputs, decoded from the next state.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            rs_q    <= 1'b1;
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            cs_n_q  <= !(state_d inside {SETUP, WR_LO, WR_HI});
            wr_n_q  <= (state_d != WR_LO);
        end
    end

`ifdef LCD8080_REPEAT_EN
    // Remaining repetitions of the word on the bus.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`endif

    assign lcd_cs_n = cs_n_q;
    assign lcd_wr_n = wr_n_q;
    assign lcd_rd_n = 1'b1;
    assign lcd_rs   = rs_q;
    assign lcd_data = data_q;
    assign busy     = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_lcd8080_stream_writer.sv
// Self-checking bench for lcd8080_stream_writer (default parameters).
// Panel activity is logged every cycle; completed writes are recovered from
// wr_n rising edges and compared against the queue of words the bench sent.
`timescale 1ns/1ps
module tb_lcd8080_stream_writer;
    import lcd8080_pkg::*;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int LO     = 2;
    localparam int HI     = 2;
    localparam int GAP    = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lcd8080_stream_writer_if #(.DATA_W(DATA_W)) s_if ();

    logic                          cs_n, rs, rd_n, wr_n, busy;
    logic [DATA_W-1:0]             data;
    logic [$clog2(DEPTH+1)-1:0]    level;

    lcd8080_stream_writer #(
        .DATA_W      (DATA_W),
        .FIFO_DEPTH  (DEPTH),
        .WR_LOW_CYC  (LO),
        .WR_HIGH_CYC (HI),
        .CS_IDLE_CYC (GAP)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .s_if          (s_if),
        .lcd_cs_n      (cs_n),
        .lcd_rs        (rs),
        .lcd_rd_n      (rd_n),
        .lcd_wr_n      (wr_n),
        .lcd_data      (data),
        .busy          (busy),
        .fifo_level    (level)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Per-cycle log of panel pins and FIFO status, sampled mid-cycle.
    logic              q_cs[$], q_wr[$], q_rs[$], q_rdy[$];
    logic [DATA_W-1:0] q_data[$];
    int                q_lvl[$];

    always @(negedge clk) begin
        q_cs.push_back(cs_n);
        q_wr.push_back(wr_n);
        q_rs.push_back(rs);
        q_rdy.push_back(s_if.in_ready);
        q_data.push_back(data);
        q_lvl.push_back(int'(level));
    end

    // Writes recovered from the log: value, rs, edge index, timing ok.
    logic [DATA_W-1:0] w_data[$];
    logic              w_rs[$];
    int                w_at[$];
    logic              w_ok[$];

    task automatic collect(input int from);
        logic ok;
        w_data.delete(); w_rs.delete(); w_at.delete(); w_ok.delete();
        for (int i = from + LO + 1; i <= q_wr.size() - HI; i++) begin
            if (q_wr[i-1] === 1'b0 && q_wr[i] === 1'b1) begin
                ok = (q_wr[i-LO-1] === 1'b1);
                for (int k = 1; k <= LO; k++)
                    if (q_wr[i-k] !== 1'b0 || q_cs[i-k] !== 1'b0 ||
                        q_data[i-k] !== q_data[i-1] || q_rs[i-k] !== q_rs[i-1]) ok = 1'b0;
                for (int k = 0; k < HI; k++)
                    if (q_cs[i+k] !== 1'b0 || q_data[i+k] !== q_data[i-1] ||
                        q_rs[i+k] !== q_rs[i-1]) ok = 1'b0;
                w_data.push_back(q_data[i-1]);
                w_rs.push_back(q_rs[i-1]);
                w_at.push_back(i);
                w_ok.push_back(ok);
            end
        end
    endtask

    // Offer one word and hold it until accepted; returns one cycle after the handshake.
    task automatic send(input logic [DATA_W-1:0] d, input logic r, input logic l, input int cnt);
        logic acc;
        int   budget;
        s_if.in_valid = 1'b1;
        s_if.in_data  = d;
        s_if.in_rs    = r;
        s_if.in_last  = l;
`ifdef LCD8080_REPEAT_EN
        s_if.in_count = 16'(cnt);
`endif
        budget = 0;
        do begin
            acc = s_if.in_ready;
            @(posedge clk); #1;
            budget++;
        end while (!acc && budget < 400);
        s_if.in_valid = 1'b0;
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL send_accept: word %h not accepted within %0d cycles (cnt %0d)", d, budget, cnt);
        end
    endtask

    task automatic wait_idle(input int limit);
        int c;
        c = 0;
        while ((busy !== 1'b0 || cs_n !== 1'b1) && c < limit) begin
            @(posedge clk); #1;
            c++;
        end
        n_checks++;
        if (busy !== 1'b0 || cs_n !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_timeout: busy=%b cs_n=%b after %0d cycles, want busy=0 cs_n=1", busy, cs_n, c);
        end
    endtask

    task automatic test_reset();
        n_checks += 8;
        if (cs_n !== 1'b1)   begin n_fail++; $display("FAIL rst_cs_n: got %b want 1", cs_n); end
        if (wr_n !== 1'b1)   begin n_fail++; $display("FAIL rst_wr_n: got %b want 1", wr_n); end
        if (rd_n !== 1'b1)   begin n_fail++; $display("FAIL rst_rd_n: got %b want 1", rd_n); end
        if (rs !== 1'b1)     begin n_fail++; $display("FAIL rst_rs: got %b want 1", rs); end
        if (data !== '0)     begin n_fail++; $display("FAIL rst_data: got %h want 0", data); end
        if (s_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", s_if.in_ready); end
        if (busy !== 1'b0)   begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (level !== '0)    begin n_fail++; $display("FAIL rst_level: got %0d want 0", level); end
    endtask

    // One command word: cycle-by-cycle strobe shape from the push onwards.
    task automatic test_single_cmd();
        logic exp_cs [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic exp_wr [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        send(16'h002C, 1'b0, 1'b1, 0);
        n_checks++;
        if (level !== 1) begin n_fail++; $display("FAIL single_level: got %0d want 1", level); end
        for (int c = 0; c < 9; c++) begin
            n_checks += 2;
            if (cs_n !== exp_cs[c]) begin n_fail++; $display("FAIL single_cs_n cycle %0d: got %b want %b", c + 1, cs_n, exp_cs[c]); end
            if (wr_n !== exp_wr[c]) begin n_fail++; $display("FAIL single_wr_n cycle %0d: got %b want %b", c + 1, wr_n, exp_wr[c]); end
            if (c >= 1) begin
                n_checks++;
                if (data !== 16'h002C || rs !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_bus cycle %0d: got %h/rs=%b want 002c/rs=0", c + 1, data, rs);
                end
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] words [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        int from;
        from = q_wr.size();
        for (int k = 0; k < 4; k++) send(words[k], 1'b1, (k == 3), 0);
        wait_idle(100);
        collect(from);
        n_checks++;
        if (w_data.size() != 4) begin n_fail++; $display("FAIL b2b_count: got %0d writes want 4", w_data.size()); end
        for (int k = 0; k < 4 && k < w_data.size(); k++) begin
            n_checks += 3;
            if (w_data[k] !== words[k] || w_rs[k] !== 1'b1) begin n_fail++; $display("FAIL b2b_word %0d: got %h/rs=%b want %h/rs=1", k, w_data[k], w_rs[k], words[k]); end
            if (w_ok[k] !== 1'b1) begin n_fail++; $display("FAIL b2b_timing %0d: got %b want 1", k, w_ok[k]); end
            if (k > 0 && w_at[k] - w_at[k-1] != LO + HI) begin n_fail++; $display("FAIL b2b_spacing %0d: got %0d want %0d", k, w_at[k] - w_at[k-1], LO + HI); end
            else if (k > 0) begin
                for (int i = w_at[k-1]; i < w_at[k]; i++)
                    if (q_cs[i] !== 1'b0) begin n_fail++; $display("FAIL b2b_cs_break at log %0d: got %b want 0", i, q_cs[i]); break; end
            end
        end
    endtask

    task automatic test_fill();
        logic [DATA_W-1:0] exp_d[$];
        logic              exp_r[$];
        int from, bad, peak;
        from = q_wr.size();
        for (int k = 0; k < 20; k++) begin
            exp_d.push_back(16'($urandom));
            exp_r.push_back(1'($urandom));
        end
        for (int k = 0; k < 20; k++) send(exp_d[k], exp_r[k], (k == 19), 0);
        wait_idle(400);
        collect(from);
        bad = 0; peak = 0;
        for (int i = from; i < q_lvl.size(); i++) begin
            if (q_lvl[i] > peak) peak = q_lvl[i];
            if (q_rdy[i] !== (q_lvl[i] != DEPTH)) bad++;
        end
        n_checks += 3;
        if (peak != DEPTH) begin n_fail++; $display("FAIL fill_peak_level: got %0d want %0d", peak, DEPTH); end
        if (bad != 0) begin n_fail++; $display("FAIL fill_ready_vs_level: got %0d bad cycles want 0", bad); end
        if (w_data.size() != 20) begin n_fail++; $display("FAIL fill_count: got %0d writes want 20", w_data.size()); end
        for (int k = 0; k < 20 && k < w_data.size(); k++) begin
            n_checks++;
            if (w_data[k] !== exp_d[k] || w_rs[k] !== exp_r[k] || w_ok[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_word %0d: got %h/rs=%b/ok=%b want %h/rs=%b/ok=1", k, w_data[k], w_rs[k], w_ok[k], exp_d[k], exp_r[k]);
            end
        end
    endtask

    task automatic test_source_gap();
        send(16'hA5A5, 1'b1, 1'b0, 0);
        for (int c = 1; c <= 10; c++) begin
            if (c >= 7) begin
                n_checks++;
                if (cs_n !== 1'b0 || wr_n !== 1'b1 || data !== 16'hA5A5) begin
                    n_fail++;
                    $display("FAIL gap_hold cycle %0d: got cs_n=%b wr_n=%b data=%h want 0/1/a5a5", c, cs_n, wr_n, data);
                end
            end
            @(posedge clk); #1;
        end
        send(16'h5A5A, 1'b0, 1'b1, 0);
        n_checks++;
        if (cs_n !== 1'b0 || wr_n !== 1'b1) begin n_fail++; $display("FAIL gap_arrive: got cs_n=%b wr_n=%b want 0/1", cs_n, wr_n); end
        @(posedge clk); #1;
        n_checks++;
        if (wr_n !== 1'b0 || data !== 16'h5A5A || rs !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_strobe_b: got wr_n=%b data=%h rs=%b want 0/5a5a/0", wr_n, data, rs);
        end
        wait_idle(100);
    endtask

    task automatic test_reset_mid();
        int   falls, budget, from;
        logic prev;
        send(16'h0101, 1'b1, 1'b0, 0);
        send(16'h0202, 1'b1, 1'b0, 0);
        send(16'h0303, 1'b1, 1'b1, 0);
        falls = 0; prev = 1'b1; budget = 0;
        while (falls < 2 && budget < 50) begin
            if (prev && !wr_n) falls++;
            prev = wr_n;
            if (falls < 2) begin @(posedge clk); #1; budget++; end
        end
        n_checks++;
        if (falls != 2) begin n_fail++; $display("FAIL rstmid_reach: got %0d wr_n falls want 2", falls); end
        #2 rst_n = 1'b0;
        #1;
        n_checks += 5;
        if (cs_n !== 1'b1)  begin n_fail++; $display("FAIL rstmid_cs_n: got %b want 1", cs_n); end
        if (wr_n !== 1'b1)  begin n_fail++; $display("FAIL rstmid_wr_n: got %b want 1", wr_n); end
        if (level !== '0)   begin n_fail++; $display("FAIL rstmid_level: got %0d want 0", level); end
        if (busy !== 1'b0)  begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        if (s_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", s_if.in_ready); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        from = q_wr.size();
        send(16'hBEEF, 1'b1, 1'b1, 0);
        wait_idle(100);
        collect(from);
        n_checks++;
        if (w_data.size() != 1 || w_data[0] !== 16'hBEEF || w_ok[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_after: got %0d writes first=%h want 1 write beef", w_data.size(), (w_data.size() > 0) ? w_data[0] : 16'h0);
        end
    endtask

    // Random words, flags, gaps (and repeat counts when enabled) vs. an expected write queue.
    task automatic test_random();
        logic [DATA_W-1:0] exp_d[$];
        logic              exp_r[$];
        logic [DATA_W-1:0] d;
        logic              r, l;
        int from, n_last, n_rise, cnt;
        from = q_wr.size();
        n_last = 0;
        for (int k = 0; k < 40; k++) begin
            d   = 16'($urandom);
            r   = 1'($urandom);
            l   = (k == 39) || ($urandom_range(0, 4) == 0);
            cnt = 0;
`ifdef LCD8080_REPEAT_EN
            cnt = $urandom_range(0, 2);
`endif
            for (int j = 0; j <= cnt; j++) begin exp_d.push_back(d); exp_r.push_back(r); end
            if (l) n_last++;
            send(d, r, l, cnt);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        wait_idle(2000);
        collect(from);
        n_rise = 0;
        for (int i = from + 1; i < q_cs.size(); i++)
            if (q_cs[i-1] === 1'b0 && q_cs[i] === 1'b1) n_rise++;
        n_checks += 2;
        if (n_rise != n_last) begin n_fail++; $display("FAIL rand_bursts: got %0d cs_n releases want %0d", n_rise, n_last); end
        if (w_data.size() != exp_d.size()) begin n_fail++; $display("FAIL rand_count: got %0d writes want %0d", w_data.size(), exp_d.size()); end
        for (int k = 0; k < exp_d.size() && k < w_data.size(); k++) begin
            n_checks++;
            if (w_data[k] !== exp_d[k] || w_rs[k] !== exp_r[k] || w_ok[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_word %0d: got %h/rs=%b/ok=%b want %h/rs=%b/ok=1", k, w_data[k], w_rs[k], w_ok[k], exp_d[k], exp_r[k]);
            end
        end
    endtask

`ifdef LCD8080_REPEAT_EN
    task automatic test_repeat();
        int from, drops, last_at;
        from = q_wr.size();
        send(16'hF800, 1'b1, 1'b1, 3);
        wait_idle(200);
        collect(from);
        drops = 0;
        for (int i = from + 1; i < q_lvl.size(); i++)
            if (q_lvl[i] < q_lvl[i-1]) drops++;
        n_checks += 2;
        if (w_data.size() != 4) begin n_fail++; $display("FAIL rep_count: got %0d writes want 4", w_data.size()); end
        if (drops != 1) begin n_fail++; $display("FAIL rep_pops: got %0d pops want 1", drops); end
        for (int k = 0; k < w_data.size(); k++) begin
            n_checks++;
            if (w_data[k] !== 16'hF800 || w_ok[k] !== 1'b1 || (k > 0 && w_at[k] - w_at[k-1] != LO + HI)) begin
                n_fail++;
                $display("FAIL rep_word %0d: got %h/ok=%b want f800/ok=1 at spacing %0d", k, w_data[k], w_ok[k], LO + HI);
            end
        end
        if (w_at.size() > 0) begin
            last_at = w_at[w_at.size() - 1] + HI;
            n_checks++;
            if (q_cs[last_at] !== 1'b1) begin n_fail++; $display("FAIL rep_cs_gap: got cs_n=%b want 1", q_cs[last_at]); end
        end
    endtask
`endif

    initial begin
        s_if.in_valid = 1'b0;
        s_if.in_data  = '0;
        s_if.in_rs    = 1'b0;
        s_if.in_last  = 1'b0;
`ifdef LCD8080_REPEAT_EN
        s_if.in_count = '0;
`endif
        #12;
        test_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        test_single_cmd();
        test_back_to_back();
        test_fill();
        test_source_gap();
        test_reset_mid();
`ifdef LCD8080_REPEAT_EN
        test_repeat();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
